product_accumulator: RTL and testbench

Downstream consumer of sequential_multiplier. It counts a programmed burst of signed products, accumulates them into a guard-bit-extended register and presents the sum on a valid/ready output port. It converts the multiplier's done/product pair into dot-product results for the next datapath stage.

---
 rtl/product_accumulator.sv | 148 ++++++++++++++
 tb/tb_product_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Purpose: sums a programmed burst of signed multiplier products into a guard-extended accumulator.
// Latency: result is presented on the clock edge that captures the final product.
// Backpressure: result held in HOLD until out_ready; products and start are ignored meanwhile.
// Optional feature: define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
    parameter int W     = 32,
    parameter int G     = 8,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    input  logic [2*W-1:0]       in_product,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*W+G-1:0]     out_result,
    output logic                 overflow
);

    localparam int PW    = 2 * W;
    localparam int ACC_W = 2 * W + G;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               in_prev_q;

    logic               accept;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_raw;
    logic               ovf_now;
    logic [ACC_W-1:0]   sum_next;

    // A product counts only on the rising edge of the upstream done, and only while
    // a burst is open; a level held high or an edge seen elsewhere is dropped.
    assign accept = in_valid & ~in_prev_q & (state_q == ACCUM);

    // Sign-extend the product up to the accumulator width (works for G == 0 too).
    assign prod_ext = ACC_W'($signed(in_product));

    assign sum_raw = acc_q + prod_ext;

    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf_now = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef ACC_SATURATE_EN
    // Clamp towards the operands' common sign; later adds continue from the clamp.
    always_comb begin
        sum_next = sum_raw;
        if (ovf_now) begin
            if (acc_q[ACC_W-1]) begin
                sum_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end
`else
    // Two's-complement wrap; the overflow flag still records the event.
    always_comb begin
        sum_next = sum_raw;
    end
`endif

    // Next-state and datapath update for the burst FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        acc_d   = '0;
                        cnt_d   = len;
                        state_d = ACCUM;
                    end else begin
                        // Empty burst: present a zero result straight away.
                        res_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_next;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (ovf_now) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == LEN_W'(1)) begin
                        res_d   = sum_next;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // out_valid is asserted for the whole of HOLD, so ready alone completes it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            in_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            in_prev_q <= in_valid;
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == HOLD);
    assign out_result = res_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Purpose: self-checking bench for product_accumulator (wide and narrow instances in lockstep).
// Latency: results checked one edge after the final product pulse.
// Backpressure: out_ready held low across extra pulses and starts to confirm the result holds.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_product;
    logic [7:0]  in_product_s;

    logic        busy, out_valid, overflow;
    logic [71:0] out_result;
    logic        busy_s, out_valid_s, overflow_s;
    logic [7:0]  out_result_s;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.W(32), .G(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_product(in_product),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .overflow(overflow)
    );

    product_accumulator #(.W(4), .G(0), .LEN_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_product(in_product_s),
        .busy(busy_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_result(out_result_s), .overflow(overflow_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int                len;
        logic [3:0][63:0]  p;
        logic [71:0]       exp;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[7:0];
        tick();
        start = 1'b0;
    endtask

    task automatic pulse(input logic [63:0] p, input logic [7:0] ps, input int hold);
        in_product   = p;
        in_product_s = ps;
        in_valid     = 1'b1;
        repeat (hold) tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk(name, 72'(out_valid), 72'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    localparam logic signed [79:0] AMAX = (80'sd1 <<< 71) - 80'sd1;
    localparam logic signed [79:0] AMIN = -(80'sd1 <<< 71);

    initial begin
        logic [7:0] e_a, e_b, e_c;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_product = '0; in_product_s = '0;

        tbl[0].len = 3; tbl[0].p = '0;
        tbl[0].p[0] = 64'(150); tbl[0].p[1] = 64'(-300); tbl[0].p[2] = 64'(64);
        tbl[0].exp = 72'(-86);
        tbl[1].len = 1; tbl[1].p = '0;
        tbl[1].p[0] = 64'(-5);
        tbl[1].exp = 72'(-5);
        tbl[2].len = 4;
        for (int k = 0; k < 4; k++) tbl[2].p[k] = 64'h7FFF_FFFF_FFFF_FFFF;
        tbl[2].exp = 72'h01_FFFF_FFFF_FFFF_FFFC;
        tbl[3].len = 3; tbl[3].p = '0;
        for (int k = 0; k < 3; k++) tbl[3].p[k] = 64'h8000_0000_0000_0000;
        tbl[3].exp = 72'hFE_8000_0000_0000_0000;

        repeat (2) tick();
        chk("rst_valid", 72'(out_valid), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_result", out_result, 72'd0);
        chk("rst_ovf", 72'(overflow), 72'd0);
        rst = 1'b0;
        tick();

        // Table-driven bursts, one pulse per product.
        for (int i = 0; i < 4; i++) begin
            do_start(tbl[i].len);
            chk("tbl_busy", 72'(busy), 72'd1);
            for (int k = 0; k < tbl[i].len; k++) pulse(tbl[i].p[k], 8'd0, 1);
            wait_valid("tbl_valid");
            chk("tbl_result", out_result, tbl[i].exp);
            chk("tbl_ovf", 72'(overflow), 72'd0);
            handshake();
            chk("tbl_drop", 72'(out_valid), 72'd0);
        end

        // Zero-length burst.
        do_start(0);
        chk("len0_valid", 72'(out_valid), 72'd1);
        chk("len0_result", out_result, 72'd0);
        handshake();
        chk("len0_busy", 72'(busy), 72'd0);

        // Held-high done counts once.
        do_start(2);
        pulse(64'd10, 8'd0, 4);
        chk("held_not_done", 72'(out_valid), 72'd0);
        pulse(64'd11, 8'd0, 1);
        wait_valid("held_valid");
        chk("held_result", out_result, 72'd21);
        handshake();

        // Edge in IDLE is not queued.
        pulse(64'd99, 8'd0, 1);
        do_start(1);
        pulse(64'd7, 8'd0, 1);
        wait_valid("idle_edge_valid");
        chk("idle_edge_result", out_result, 72'd7);
        handshake();

        // Backpressure with stray pulses and starts.
        do_start(2);
        pulse(64'd50, 8'd0, 1);
        pulse(64'd60, 8'd0, 1);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1; len = 8'd1; in_product = 64'd1000; in_valid = (c % 2 == 0);
            tick();
            chk("bp_result", out_result, 72'd110);
            chk("bp_valid", 72'(out_valid), 72'd1);
        end
        start = 1'b0; in_valid = 1'b0;
        start = 1'b1; len = 8'd1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("bp_exit_busy", 72'(busy), 72'd0);
        chk("bp_exit_valid", 72'(out_valid), 72'd0);

        // Reset mid-burst.
        do_start(3);
        pulse(64'd5, 8'd0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 72'(busy), 72'd0);
        chk("mrst_valid", 72'(out_valid), 72'd0);
        chk("mrst_result", out_result, 72'd0);
        chk("mrst_ovf", 72'(overflow), 72'd0);
        do_start(1);
        pulse(64'(-5), 8'd0, 1);
        wait_valid("mrst_new_valid");
        chk("mrst_new_result", out_result, 72'(-5));
        chk("mrst_new_ovf", 72'(overflow), 72'd0);
        handshake();

        // Narrow instance: ACC_W = 8 overflow behaviour.
`ifdef ACC_SATURATE_EN
        e_a = 8'h7F; e_b = 8'h4D; e_c = 8'h80;
`else
        e_a = 8'h80; e_b = 8'h96; e_c = 8'h38;
`endif
        do_start(2);
        pulse(64'd0, 8'd64, 1);
        pulse(64'd0, 8'd64, 1);
        wait_valid("s1_valid");
        chk("s1_result", 72'(out_result_s), 72'(e_a));
        chk("s1_ovf", 72'(overflow_s), 72'd1);
        handshake();
        do_start(3);
        pulse(64'd0, 8'd100, 1);
        pulse(64'd0, 8'd100, 1);
        pulse(64'd0, 8'(-50), 1);
        wait_valid("s2_valid");
        chk("s2_result", 72'(out_result_s), 72'(e_b));
        chk("s2_ovf", 72'(overflow_s), 72'd1);
        handshake();
        do_start(2);
        pulse(64'd0, 8'(-100), 1);
        pulse(64'd0, 8'(-100), 1);
        wait_valid("s3_valid");
        chk("s3_result", 72'(out_result_s), 72'(e_c));
        chk("s3_ovf", 72'(overflow_s), 72'd1);
        handshake();
        do_start(1);
        chk("s4_ovf_cleared", 72'(overflow_s), 72'd0);
        pulse(64'd0, 8'(-5), 1);
        wait_valid("s4_valid");
        chk("s4_result", 72'(out_result_s), 72'hFB);
        handshake();

        // Randomized bursts against an exact-arithmetic model.
        for (int b = 0; b < 30; b++) begin
            int l;
            logic signed [79:0] ex;
            logic ovf_m;
            logic [63:0] p;
            l = $urandom_range(1, 6);
            ex = '0;
            ovf_m = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            do_start(l);
            for (int k = 0; k < l; k++) begin
                p = {$urandom, $urandom};
                ex = ex + 80'($signed(p));
                if (ex > AMAX || ex < AMIN) begin
                    ovf_m = 1'b1;
`ifdef ACC_SATURATE_EN
                    ex = (ex > AMAX) ? AMAX : AMIN;
`else
                    ex = 80'($signed(ex[71:0]));
`endif
                end
                pulse(p, 8'd0, $urandom_range(1, 3));
                repeat ($urandom_range(0, 1)) tick();
            end
            wait_valid("rnd_valid");
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_result", out_result, ex[71:0]);
            chk("rnd_ovf", 72'(overflow), 72'(ovf_m));
            handshake();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
